// File: rtl/f_le_share_arbiter_pkg.sv
// Shared types for the float less-or-equal comparator share arbiter:
// requester id width and the in-flight tracker entry.
package f_le_arb_pkg;

  localparam int NREQ_MAX = 8;
  localparam int LAT_MAX  = 4;
  localparam int ID_W     = $clog2(NREQ_MAX);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } inflight_t;

endpackage

// File: rtl/f_le_share_arbiter_if.sv
// Requester-side bundle: compare requests in, grants and per-requester result pulses out.
interface f_le_share_arbiter_if #(
  parameter int FLEN = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][FLEN-1:0] req_a;
  logic [NREQ-1:0][FLEN-1:0] req_b;
  logic [NREQ-1:0]           rsp_valid;
  logic [NREQ-1:0]           rsp_res;
  logic [NREQ-1:0]           rsp_err;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_res, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_res, rsp_err
  );
endinterface

// File: rtl/f_le_share_arbiter_rr.sv
// Round-robin one-hot grant over NREQ requesters; priority starts at ptr and
// ptr moves just past the winner on every grant.
module rr_arbiter
  import f_le_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            gnt_any,
  output req_id_t         gnt_id
);
  req_id_t ptr;

  // Offset k walks priority order from ptr; first requesting slot wins.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (rst) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!gnt_any && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
            grant[i] = 1'b1;
            gnt_any  = 1'b1;
            gnt_id   = req_id_t'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == req_id_t'(NREQ - 1)) ? '0 : gnt_id + req_id_t'(1);
    end
  end

endmodule

// File: rtl/f_le_share_arbiter.sv
// Shares one float a<=b comparator among NREQ requesters: round-robin grant,
// LAT-deep in-flight tracker, registered one-cycle response per requester.
module f_le_share_arbiter
  import f_le_arb_pkg::*;
#(
  parameter int FLEN = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  f_le_share_arbiter_if.slave bus,
  output logic [FLEN-1:0]     f_le_a,
  output logic [FLEN-1:0]     f_le_b,
  input  logic                f_le_res,
  input  logic                f_le_err,
  output logic [7:0]          err_cnt,
  output logic                busy
);
  logic [NREQ-1:0] grant;
  logic            gnt_any;
  req_id_t         gnt_id;
  inflight_t       ent_p0;
  inflight_t       ent_out;
  logic            trk_any;
  logic [NREQ-1:0] rsp_valid_q;
  logic [NREQ-1:0] rsp_res_q;
  logic [NREQ-1:0] rsp_err_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .grant   (grant),
    .gnt_any (gnt_any),
    .gnt_id  (gnt_id)
  );

  assign bus.req_ready = grant;

  // Grant is one-hot or zero, so an AND-OR mux drives zeros when idle.
  always_comb begin
    f_le_a = '0;
    f_le_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      f_le_a |= {FLEN{grant[i]}} & bus.req_a[i];
      f_le_b |= {FLEN{grant[i]}} & bus.req_b[i];
    end
  end

  // Stage 0: the grant of the current cycle
  assign ent_p0 = '{valid: gnt_any, id: gnt_id};

  generate
    if (LAT == 0) begin : g_comb
      assign ent_out = ent_p0;
      assign trk_any = 1'b0;
    end else begin : g_pipe
      inflight_t trk_p [LAT];

      // Stages 1..LAT: registered entries following the comparator latency
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < LAT; s++) trk_p[s] <= '0;
        end else begin
          trk_p[0] <= ent_p0;
          for (int s = 1; s < LAT; s++) trk_p[s] <= trk_p[s-1];
        end
      end

      always_comb begin
        trk_any = 1'b0;
        for (int s = 0; s < LAT; s++) trk_any |= trk_p[s].valid;
      end

      assign ent_out = trk_p[LAT-1];
    end
  endgenerate

  // Output stage: comparator result lands in the addressed requester's registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= '0;
      err_cnt     <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (ent_out.valid) begin
        for (int i = 0; i < NREQ; i++) begin
          if (ent_out.id == req_id_t'(i)) begin
            rsp_valid_q[i] <= 1'b1;
            rsp_res_q[i]   <= f_le_res & ~f_le_err;
            rsp_err_q[i]   <= f_le_err;
          end
        end
        if (f_le_err) err_cnt <= sat_inc8(err_cnt);
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_err   = rsp_err_q;

  assign busy = (|bus.req_valid) | trk_any;

endmodule

// File: tb/tb_f_le_share_arbiter.sv
// Directed bench for f_le_share_arbiter: a LAT=0 and a LAT=2 instance, each
// driven by a behavioural float a<=b comparator model.
module tb_f_le_share_arbiter;

  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] NAN  = 32'h7FC00000;
  localparam logic [31:0] ZERO = 32'h00000000;
  localparam logic [31:0] MONE = 32'hBF800000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  f_le_share_arbiter_if #(.FLEN(32), .NREQ(4)) if0 ();
  f_le_share_arbiter_if #(.FLEN(32), .NREQ(4)) if2 ();

  logic [31:0] fa0, fb0, fa2, fb2;
  logic        fr0, fe0, fr2, fe2;
  logic [7:0]  ec0, ec2;
  logic        busy0, busy2;
  logic [1:0]  cmp_d1, cmp_d2;
  logic [3:0]  exp_v;
  logic [3:0]  exp_res;

  // Returns {err, res}: NaN operand -> error; +0 == -0; else ordered-key compare.
  function automatic logic [1:0] fle(input logic [31:0] a, input logic [31:0] b);
    logic        an, bn;
    logic [31:0] ka, kb;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (an || bn) return 2'b10;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 2'b01;
    ka = a[31] ? ~a : (a | 32'h80000000);
    kb = b[31] ? ~b : (b | 32'h80000000);
    return {1'b0, ka <= kb};
  endfunction

  assign {fe0, fr0} = fle(fa0, fb0);

  always @(posedge clk) begin
    cmp_d1 <= fle(fa2, fb2);
    cmp_d2 <= cmp_d1;
  end
  assign {fe2, fr2} = cmp_d2;

  f_le_share_arbiter #(.FLEN(32), .NREQ(4), .LAT(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if0),
    .f_le_a   (fa0),
    .f_le_b   (fb0),
    .f_le_res (fr0),
    .f_le_err (fe0),
    .err_cnt  (ec0),
    .busy     (busy0)
  );

  f_le_share_arbiter #(.FLEN(32), .NREQ(4), .LAT(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if2),
    .f_le_a   (fa2),
    .f_le_b   (fb2),
    .f_le_res (fr2),
    .f_le_err (fe2),
    .err_cnt  (ec2),
    .busy     (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.req_valid = '0; if0.req_a = '0; if0.req_b = '0;
    if2.req_valid = '0; if2.req_a = '0; if2.req_b = '0;

    // Reset: requests present but no grant while rst is low
    rst = 1'b0;
    if2.req_valid = 4'hF;
    repeat (2) cyc();
    #2;
    chk("rst_ready2", if2.req_ready, 4'h0);
    chk("rst_ready0", if0.req_ready, 4'h0);
    chk("rst_rspv2", if2.rsp_valid, 4'h0);
    chk("rst_errcnt2", ec2, 8'd0);
    chk("rst_errcnt0", ec0, 8'd0);
    chk("rst_ptr2", dut2.u_arb.ptr, 0);
    chk("rst_busy2", busy2, 1);
    if2.req_valid = 4'h0;
    cyc();
    rst = 1'b1;

    // Single requester, LAT=0
    cyc();
    if0.req_valid = 4'b0010; if0.req_a[1] = ONE; if0.req_b[1] = TWO;
    #2;
    chk("s_ready", if0.req_ready, 4'b0010);
    chk("s_fa", fa0, ONE);
    chk("s_fb", fb0, TWO);
    cyc();
    if0.req_valid = 4'b0000;
    #2;
    chk("s_rspv", if0.rsp_valid, 4'b0010);
    chk("s_res", if0.rsp_res[1], 1);
    chk("s_err", if0.rsp_err[1], 0);
    chk("s_idle_a", fa0, ZERO);
    chk("s_ptr", dut0.u_arb.ptr, 2);
    chk("s_busy", busy0, 0);
    cyc();
    if0.req_valid = 4'b0010; if0.req_a[1] = TWO; if0.req_b[1] = ONE;
    #2;
    chk("s_pulse", if0.rsp_valid, 4'b0000);
    chk("s_hold", if0.rsp_res[1], 1);
    chk("s_ready2", if0.req_ready, 4'b0010);
    cyc();
    if0.req_valid = 4'b0000;
    #2;
    chk("s_rspv2", if0.rsp_valid, 4'b0010);
    chk("s_res2", if0.rsp_res[1], 0);

    // Round-robin, LAT=2: all four request for 8 cycles
    for (int i = 0; i < 4; i++) if2.req_a[i] = ONE;
    if2.req_b[0] = TWO; if2.req_b[1] = ONE; if2.req_b[2] = ZERO; if2.req_b[3] = MONE;
    exp_res = 4'b0011;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if2.req_valid = (k < 8) ? 4'hF : 4'h0;
      #2;
      chk($sformatf("rr_ready%0d", k), if2.req_ready, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
      exp_v = (k >= 3 && k < 11) ? (4'b0001 << ((k - 3) % 4)) : 4'b0000;
      chk($sformatf("rr_rspv%0d", k), if2.rsp_valid, exp_v);
      if (exp_v != 4'b0000)
        chk($sformatf("rr_res%0d", k), if2.rsp_res & exp_v, exp_res & exp_v);
      if (k == 9)  chk("rr_busy_inflight", busy2, 1);
      if (k == 10) chk("rr_busy_idle", busy2, 0);
    end

    // Comparator error from requester 2, then a normal compare
    cyc();
    if2.req_valid = 4'b0100; if2.req_a[2] = NAN; if2.req_b[2] = ONE;
    #2;
    chk("e_ready", if2.req_ready, 4'b0100);
    cyc();
    if2.req_valid = 4'b0000; if2.req_a[2] = ONE; if2.req_b[2] = TWO;
    cyc();
    cyc();
    #2;
    chk("e_rspv", if2.rsp_valid, 4'b0100);
    chk("e_err", if2.rsp_err[2], 1);
    chk("e_res", if2.rsp_res[2], 0);
    chk("e_cnt", ec2, 8'd1);
    if2.req_valid = 4'b0100;
    cyc();
    if2.req_valid = 4'b0000;
    cyc();
    cyc();
    #2;
    chk("e2_rspv", if2.rsp_valid, 4'b0100);
    chk("e2_err", if2.rsp_err[2], 0);
    chk("e2_res", if2.rsp_res[2], 1);
    chk("e2_cnt", ec2, 8'd1);

    // Reset with two compares in flight
    cyc();
    if2.req_valid = 4'b0001; if2.req_a[0] = ONE; if2.req_b[0] = TWO;
    cyc();
    if2.req_valid = 4'b0010;
    cyc();
    if2.req_valid = 4'b0000;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("mr_rspv%0d", k), if2.rsp_valid, 4'b0000);
      cyc();
    end
    chk("mr_ptr", dut2.u_arb.ptr, 0);
    chk("mr_cnt", ec2, 8'd0);
    chk("mr_busy", busy2, 0);
    chk("mr_res", if2.rsp_res, 4'b0000);

    // 260 NaN compares from requester 3: saturation and pointer wrap
    if2.req_a[3] = NAN; if2.req_b[3] = ONE;
    for (int k = 0; k < 263; k++) begin
      cyc();
      if2.req_valid = (k < 260) ? 4'b1000 : 4'b0000;
      #2;
      if (k == 0 || k == 259) chk($sformatf("sat_ready%0d", k), if2.req_ready, 4'b1000);
      if (k == 1 || k == 259) chk($sformatf("sat_ptr%0d", k), dut2.u_arb.ptr, 0);
      if (k == 100) chk("sat_cnt98", ec2, 8'd98);
      if (k == 257) chk("sat_cnt255", ec2, 8'd255);
      if (k == 262) begin
        chk("sat_cnt_hold", ec2, 8'd255);
        chk("sat_rspv", if2.rsp_valid, 4'b1000);
        chk("sat_err", if2.rsp_err[3], 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
